// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin word arbiter.
package mux_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_priority_pick #(
    parameter int N    = 16,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] grant,
    output logic            any
);

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    rot;
    logic [IDXW-1:0] rot_idx;

    assign req_dbl = {req, req} >> ptr;
    assign rot     = req_dbl[N-1:0];

    always_comb begin
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = IDXW'(i);
            end
        end
    end

    // N is a power of two, so the IDXW-bit sum wraps modulo N for free.
    assign grant = rot_idx + ptr;
    assign any   = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 word arbiter with a one-entry registered output stage.
// Optional packet locking is enabled with MUX_RR_ARBITER_LOCK_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              in_valid,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic [N-1:0]              in_last,
`endif
    output logic [N-1:0]              in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(N)-1:0]      out_src,
    input  logic                      out_ready
);

    localparam int IDXW = $clog2(N);

    out_state_t      state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [IDXW-1:0] src_reg;
    logic [IDXW-1:0] ptr_reg;
    logic            lock_reg;
    logic [IDXW-1:0] lock_idx_reg;

    logic [N-1:0]     eff_req;
    logic [IDXW-1:0]  grant;
    logic             any;
    logic             load;
    logic             xfer;
    logic             last_sel;
    logic [WIDTH-1:0] sel_data;

    // While locked, only the owning requester is visible to the picker.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign eff_req[gi]  = in_valid[gi] & (~lock_reg | (lock_idx_reg == IDXW'(gi)));
            assign in_ready[gi] = xfer & (grant == IDXW'(gi));
        end
    endgenerate

    rr_priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (eff_req),
        .ptr   (ptr_reg),
        .grant (grant),
        .any   (any)
    );

    assign load = (state_reg == EMPTY) | out_ready;
    assign xfer = load & any;

`ifdef MUX_RR_ARBITER_LOCK_EN
    assign last_sel = in_last[grant];
`else
    assign last_sel = 1'b1;
`endif

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDXW'(i)) begin
                sel_data = in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            data_reg     <= '0;
            src_reg      <= '0;
            ptr_reg      <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            if (xfer) begin
                state_reg <= FULL;
                data_reg  <= sel_data;
                src_reg   <= grant;
                // The pointer only moves once a whole packet has gone through.
                if (last_sel) begin
                    ptr_reg  <= IDXW'(next_idx(int'(grant), N));
                    lock_reg <= 1'b0;
                end else begin
                    lock_reg     <= 1'b1;
                    lock_idx_reg <= grant;
                end
            end else if (out_ready) begin
                state_reg <= EMPTY;
            end
        end
    end

    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;
    assign out_src   = src_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int N = 16;
    localparam int W = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        in_valid = '0;
    logic [N-1:0][W-1:0] in_data = '0;
    logic [N-1:0]        in_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [3:0]          out_src;
    logic                out_ready = 1'b0;
`ifdef MUX_RR_ARBITER_LOCK_EN
    logic [N-1:0]        in_last = '1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         ready;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        logic [3:0]   exp_src;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves the bench 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_src", out_src, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rdy", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic grant_cyc(input int exp);
        out_ready = 1'b1;
        #1;
        chk("rr_rdy", in_ready, 32'(1) << exp);
        tick();
        chk("rr_ov", out_valid, 1);
        chk("rr_src", out_src, exp);
        chk("rr_data", out_data, exp);
        $display("grant src=%0d data=%0d", out_src, out_data);
    endtask

    task automatic stall(input int held, input int cycles);
        out_ready = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            #1;
            chk("stall_rdy", in_ready, 0);
            tick();
            chk("stall_ov", out_valid, 1);
            chk("stall_src", out_src, held);
            chk("stall_data", out_data, held);
            $display("stall src=%0d data=%0d", out_src, out_data);
        end
    endtask

    task automatic random_run(input int cycles);
        int           m_ptr;
        bit           m_full;
        logic [3:0]   m_src;
        logic [W-1:0] m_data;
        logic [7:0]   q[$];
        int           wait_cnt[N];
        int           g;
        int           idx;
        bit           load;
        bit           xfer;
        logic [7:0]   exp_word;
        m_ptr  = 0;
        m_full = 0;
        m_src  = '0;
        m_data = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            chk("rnd_ov", out_valid, m_full);
            if (m_full) begin
                chk("rnd_src", out_src, m_src);
                chk("rnd_data", out_data, m_data);
            end
            if ($urandom_range(0, 7) == 0) in_valid = '1;
            else if ($urandom_range(0, 3) == 0) in_valid = '0;
            else in_valid = N'($urandom & $urandom);
            for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (in_valid[idx] && g < 0) g = idx;
            end
            load = !m_full || out_ready;
            xfer = load && (g >= 0);
            chk("rnd_rdy", in_ready, xfer ? (32'(1) << g) : 32'(0));
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    exp_word = q.pop_front();
                    chk("sb_word", {out_src, out_data}, exp_word);
                end else begin
                    chk("sb_spurious", out_valid, 0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || (xfer && i == g)) begin
                    wait_cnt[i] = 0;
                end else if (xfer) begin
                    wait_cnt[i]++;
                    chk("starve", wait_cnt[i] <= N - 1, 1);
                end
            end
            if (xfer) begin
                m_full = 1;
                m_src  = 4'(g);
                m_data = in_data[g];
                m_ptr  = (g + 1) % N;
                q.push_back({4'(g), in_data[g]});
            end else if (out_ready) begin
                m_full = 0;
            end
            tick();
        end
        chk("sb_left", q.size(), m_full);
        $display("random run %0d cycles done", cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3};
        tbl[1] = '{16'h1008, 1'b1, 16'h1000, 1'b1, 4'd12};
        tbl[2] = '{16'h1008, 1'b1, 16'h0008, 1'b1, 4'd3};
        tbl[3] = '{16'h1008, 1'b1, 16'h1000, 1'b1, 4'd12};
        tbl[4] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 4'd12};
        tbl[5] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd12};

        #2;
        do_reset();

        // All requesters valid: strict rotation, stall hold, wrap after 15.
        for (int i = 0; i < N; i++) in_data[i] = W'(i);
        in_valid = '1;
        for (int k = 0; k < 17; k++) grant_cyc(k % N);
        for (int k = 1; k <= 5; k++) grant_cyc(k);
        stall(5, 3);
        grant_cyc(6);
        for (int k = 7; k <= 15; k++) grant_cyc(k);
        stall(15, 2);
        grant_cyc(0);

        // Sparse requests from the vector table.
        do_reset();
        for (int i = 0; i < N; i++) in_data[i] = W'(i) ^ 4'h5;
        for (int k = 0; k < 6; k++) begin
            in_valid  = tbl[k].valid;
            out_ready = tbl[k].ready;
            #1;
            chk("tbl_rdy", in_ready, tbl[k].exp_rdy);
            tick();
            chk("tbl_ov", out_valid, tbl[k].exp_ov);
            if (tbl[k].exp_ov) begin
                chk("tbl_src", out_src, tbl[k].exp_src);
                chk("tbl_data", out_data, tbl[k].exp_src ^ 4'h5);
            end
            $display("vec %0d ov=%0d src=%0d data=%0d", k, out_valid, out_src, out_data);
        end

        // Reset while a word is held; ptr must return to 0.
        in_valid  = 16'h1000;
        out_ready = 1'b1;
        tick();
        chk("mid_ov_before", out_valid, 1);
        in_valid  = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_src", out_src, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_no_emit", out_valid, 0);
        in_valid  = 16'h4020;
        out_ready = 1'b1;
        #1;
        chk("mid_first_rdy", in_ready, 32'h0020);
        tick();
        chk("mid_first_src", out_src, 5);
        $display("reset release first grant src=%0d", out_src);

`ifdef MUX_RR_ARBITER_LOCK_EN
        do_reset();
        for (int i = 0; i < N; i++) in_data[i] = W'(i);
        in_last   = '0;
        in_valid  = 16'h0084;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) in_last[2] = 1'b1;
            #1;
            chk("lock_rdy", in_ready, 32'h0004);
            tick();
            chk("lock_src", out_src, 2);
            $display("lock beat %0d src=%0d", b, out_src);
        end
        in_last[7] = 1'b1;
        #1;
        chk("lock_after_rdy", in_ready, 32'h0080);
        tick();
        chk("lock_after_src", out_src, 7);
        $display("after packet src=%0d", out_src);
        in_last = '1;
`endif

        do_reset();
        random_run(10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
